// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the shift-add multiplier core and the bus peripheral
// that wraps it: default operand width, FSM state encoding and counter width.
// -----------------------------------------------------------------------------
package mult_pkg;

    // Default operand width; the product is twice this wide.
    localparam int MULT_WIDTH = 16;

    // Two-state control FSM.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bits needed to count WIDTH steps (0 .. WIDTH-1); never less than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int MULT_CNT_W = cnt_width(MULT_WIDTH);

endpackage

// File: rtl/shift_add_mult.sv
// -----------------------------------------------------------------------------
// shift_add_mult
// Sequential unsigned shift-add multiplier. One partial-product step per clock;
// a start is accepted from IDLE when init is high, and the 2*WIDTH-bit product
// is valid once the sticky done flag rises.
//
// Optional build macro: MULT_EARLY_TERM_EN
//   When defined, a run also ends as soon as no set multiplier bits remain
//   above the one being consumed, giving latency 1 + msb index of B.
//
// Ports:
//   clk   in   1        system clock, all state on posedge
//   rst   in   1        asynchronous active-low reset
//   A     in   WIDTH    multiplicand, sampled on start acceptance
//   B     in   WIDTH    multiplier, sampled on start acceptance
//   init  in   1        start request, level-sampled
//   pp    out  2*WIDTH  product register
//   done  out  1        sticky completion flag
//   busy  out  1        high while a multiplication is in progress
// -----------------------------------------------------------------------------
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               init,
    output logic [2*WIDTH-1:0] pp,
    output logic               done,
    output logic               busy
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     cnt;
    logic                 finish;

    // Last RUN step: counter exhausted, or (optionally) no multiplier bits left.
    always_comb begin
        finish = (cnt == CNT_LAST);
`ifdef MULT_EARLY_TERM_EN
        if ((mplier >> 1) == '0) begin
            finish = 1'b1;
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (init)   state_next = ST_RUN;
            ST_RUN:  if (finish) state_next = ST_IDLE;
            default:             state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_RUN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            pp     <= '0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (init) begin
                        mcand  <= {{WIDTH{1'b0}}, A};
                        mplier <= B;
                        cnt    <= '0;
                        pp     <= '0;
                        done   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Sum of shifted multiplicands never exceeds 2*WIDTH bits.
                    if (mplier[0]) begin
                        pp <= pp + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (finish) begin
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mult
// Directed self-checking bench for shift_add_mult with hand-computed products.
// Expected latencies follow MULT_EARLY_TERM_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_shift_add_mult;

    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic             init = 1'b0;
    logic [2*W-1:0]   pp;
    logic             done;
    logic             busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_add_mult #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (a),
        .B    (b),
        .init (init),
        .pp   (pp),
        .done (done),
        .busy (busy)
    );

    // Expected number of RUN edges for a given multiplier.
    function automatic int exp_lat(input logic [W-1:0] bv);
`ifdef MULT_EARLY_TERM_EN
        int h;
        h = 0;
        for (int i = 0; i < W; i++) if (bv[i]) h = i;
        return h + 1;
`else
        return W;
`endif
    endfunction

    // Present operands with init for one edge (E0); returns at E0 + 1.
    task automatic accept(input string name, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        a    = av;
        b    = bv;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: busy=%b done=%b, required busy=1 done=0", name, busy, done);
        end
    endtask

    // Count edges until done rises (bounded) and check latency, product, busy.
    task automatic wait_done(input string name, input int exp_n, input logic [2*W-1:0] exp_pp);
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) break;
        end
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL %s_latency: done after %0d edges, required %0d", name, n, exp_n);
        end
        checks++;
        if (pp !== exp_pp) begin
            errors++;
            $display("FAIL %s_pp: got 0x%08h, required 0x%08h", name, pp, exp_pp);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: got %b after done, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (pp !== '0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: pp=0x%08h done=%b busy=%b, required all 0", pp, done, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pp !== '0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: pp=0x%08h done=%b busy=%b, required all 0", pp, done, busy);
        end
    endtask

    task automatic test_basic();
        accept("basic", 16'd3, 16'd5);
        wait_done("basic", exp_lat(16'd5), 32'h0000_000F);
    endtask

    task automatic test_max();
        accept("max", 16'hFFFF, 16'hFFFF);
        wait_done("max", exp_lat(16'hFFFF), 32'hFFFE_0001);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b1 || pp !== 32'hFFFE_0001 || busy !== 1'b0) begin
                errors++;
                $display("FAIL max_hold%0d: done=%b pp=0x%08h busy=%b, required 1 0xfffe0001 0",
                         i, done, pp, busy);
            end
        end
    endtask

    task automatic test_zero();
        accept("zero", 16'h1234, 16'h0000);
        wait_done("zero", exp_lat(16'h0000), 32'h0);
    endtask

    task automatic test_busy_ignore();
`ifdef MULT_EARLY_TERM_EN
        int pulse_at = 2;
`else
        int pulse_at = 5;
`endif
        accept("ignore", 16'd7, 16'd9);
        for (int i = 1; i < pulse_at; i++) @(posedge clk);
        @(negedge clk);
        a    = 16'd1;
        b    = 16'd1;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_midrun: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        wait_done("ignore", exp_lat(16'd9) - pulse_at, 32'd63);
        accept("restart", 16'd1, 16'd1);
        wait_done("restart", exp_lat(16'd1), 32'd1);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a    = 16'd2;
        b    = 16'd3;
        init = 1'b1;
        @(posedge clk);
        #1;
        // init stays high through the whole run and across completion
        wait_done("b2b_first", exp_lat(16'd3), 32'd6);
        a = 16'd4;
        b = 16'd5;
        @(posedge clk);
        #1;
        init = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: done=%b busy=%b, required done=0 busy=1", done, busy);
        end
        wait_done("b2b_second", exp_lat(16'd5), 32'd20);
    endtask

    task automatic test_abort();
`ifdef MULT_EARLY_TERM_EN
        int abort_at = 4;
`else
        int abort_at = 8;
`endif
        accept("abort", 16'd100, 16'd200);
        for (int i = 1; i < abort_at; i++) @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1 || pp === '0) begin
            errors++;
            $display("FAIL abort_pre: busy=%b pp=0x%08h, required busy=1 and nonzero partial", busy, pp);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (pp !== '0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: pp=0x%08h done=%b busy=%b, required all 0", pp, done, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        accept("abort_fresh", 16'd100, 16'd200);
        wait_done("abort_fresh", exp_lat(16'd200), 32'd20000);
    endtask

    task automatic test_early();
        accept("early", 16'd7, 16'd2);
        wait_done("early", exp_lat(16'd2), 32'd14);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_busy_ignore();
        test_back_to_back();
        test_abort();
        test_early();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_add_mult.md
Name: shift_add_mult

Overview:
- Sequential unsigned shift-add multiplier core that sits directly downstream of the J1 bus multiplier peripheral.
- Consumes the peripheral's operand registers and start strobe; produces the 2*WIDTH-bit product and a sticky done flag.
- The peripheral exposes the product and done to the CPU for polling.
- Computes one partial-product step per clock.

Parameters:
- WIDTH, 16, operand width in bits. Product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock. All state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- A  input  WIDTH  multiplicand. Sampled only on start acceptance.
- B  input  WIDTH  multiplier. Sampled only on start acceptance.
- init  input  1  start request, level-sampled on posedge.
- pp  output  2*WIDTH  product register.
- done  output  1  sticky completion flag.
- busy  output  1  high while a multiplication is in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - pp=0, done=0, busy=0, state=IDLE.
  - Internal multiplicand, multiplier and counter cleared.
  - Reset mid-operation aborts; no partial result is retained.
- States: IDLE, RUN. busy = (state==RUN), registered.
- IDLE:
  - init=1 at edge E0 accepts a start:
    - mcand <= zero-extended A (2*WIDTH bits); mplier <= B; cnt <= 0.
    - pp <= 0; done <= 0; go to RUN.
  - init=0: hold all outputs.
- RUN, each edge:
  - If mplier[0]=1: pp <= pp + mcand (2*WIDTH-bit add, no overflow possible).
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - When cnt==WIDTH-1 on that edge: done <= 1, go to IDLE.
- Latency:
  - Start accepted at E0; final pp and done=1 visible after edge E(WIDTH), i.e. E16 for the default.
  - busy is high from after E0 through E(WIDTH).
- init while busy: ignored, with no restart and no operand resample. init held high across completion starts a new operation at the first IDLE edge, which clears done.
- done stays high and pp holds its value until the next accepted start or reset.
- A and B may change at any time after E0 without affecting the result.
- Boundary cases:
  - A=0 or B=0: runs the full WIDTH cycles; pp=0, done=1.
  - Maximum operands: pp = (2^WIDTH-1)^2 with no truncation.
- pp is not guaranteed meaningful while busy=1. Consumers qualify pp with done.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined: in RUN, the operation also finishes on any edge where (mplier>>1)==0, setting done <= 1 and returning to IDLE.
  - Latency becomes 1 + index of the highest set bit of B.
  - B=0 gives done after 1 RUN edge.
  - Result values are identical to the non-early path.
- Undefined: fixed WIDTH-cycle latency as above.

Decomposition:
- Package mult_pkg:
  - default WIDTH constant
  - state encoding localparams (ST_IDLE, ST_RUN)
  - counter width constant = clog2(WIDTH)
- The peripheral wrapper shares this package.
- No sub-module: datapath (adder, two shifters, counter) and the two-state FSM stay in one module.

Test Plan:
- Reset, then A=3, B=5, one-cycle init → busy rises after E0; done=1 and pp=0x0000000F exactly after E16; no earlier done.
- A=0xFFFF, B=0xFFFF → pp=0xFFFE0001 at done; done stays high for 20 further idle cycles, pp stable.
- A=0x1234, B=0 → pp=0, done=1 after E16 (or after 1 RUN edge with MULT_EARLY_TERM_EN).
- Start A=7, B=9; pulse init at cycle 5 with A=1, B=1 → ignored; pp=63 at E16. A new init then clears done on the accepting edge and yields pp=1.
- Start A=100, B=200; drive rst=0 at cycle 8 asynchronously → pp=0, done=0, busy=0 immediately. After release, a fresh start gives pp=20000.
- MULT_EARLY_TERM_EN: A=7, B=2 → done=1 and pp=14 after 2 RUN edges. Without the macro, same pp after 16 edges.
